// File: rtl/dict_bank_multi_if.sv
// Handshake bundle for dict_bank_multi.
//   value load stream : in_value_data/valid/last -> in_value_ready
//   id lookup streams : in_id_data/serial/keep/last/valid -> in_id_ready (one lane per channel)
//   result streams    : out_value/serial/miss/last/valid <- out_ready (one lane per channel)
// Lane c of each packed per-channel vector occupies bits [c*W +: W].
// master = the side that drives the value/id streams and consumes results; slave = the bank.
interface dict_bank_multi_if #(
  parameter int VALUE_W  = 32,
  parameter int ID_W     = 16,
  parameter int SERIAL_W = 8,
  parameter int N_CH     = 4
);
  logic [VALUE_W-1:0]       in_value_data;
  logic                     in_value_valid;
  logic                     in_value_last;
  logic                     in_value_ready;

  logic [N_CH*ID_W-1:0]     in_id_data;
  logic [N_CH*SERIAL_W-1:0] in_id_serial;
  logic [N_CH-1:0]          in_id_keep;
  logic [N_CH-1:0]          in_id_last;
  logic [N_CH-1:0]          in_id_valid;
  logic [N_CH-1:0]          in_id_ready;

  logic [N_CH*VALUE_W-1:0]  out_value;
  logic [N_CH*SERIAL_W-1:0] out_serial;
  logic [N_CH-1:0]          out_miss;
  logic [N_CH-1:0]          out_last;
  logic [N_CH-1:0]          out_valid;
  logic [N_CH-1:0]          out_ready;

  modport master (
    output in_value_data, in_value_valid, in_value_last,
    input  in_value_ready,
    output in_id_data, in_id_serial, in_id_keep, in_id_last, in_id_valid,
    input  in_id_ready,
    input  out_value, out_serial, out_miss, out_last, out_valid,
    output out_ready
  );

  modport slave (
    input  in_value_data, in_value_valid, in_value_last,
    output in_value_ready,
    input  in_id_data, in_id_serial, in_id_keep, in_id_last, in_id_valid,
    output in_id_ready,
    output out_value, out_serial, out_miss, out_last, out_valid,
    input  out_ready
  );
endinterface

// File: rtl/dict_bank_multi.sv
// dict_bank_multi: dictionary bank with N_CH parallel lookup channels.
// Loads up to DEPTH values from the value stream into one RAM replica per
// channel, then answers per-channel id lookups (1-cycle latency, full
// throughput) with bounds checking against the loaded entry count. Once every
// channel has seen its last id and all results have retired, the bank
// returns to load the next dictionary.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   bus          dict_bank_multi_if.slave (value load, id lookups, results)
//   entry_count  entries stored by the last/current load
//   overflow     sticky: the load carried more than DEPTH beats
module dict_bank_multi #(
  parameter int    VALUE_W   = 32,
  parameter int    ID_W      = 16,
  parameter int    SERIAL_W  = 8,
  parameter int    DEPTH     = 4096,
  parameter int    N_CH      = 4,
  parameter string RAM_STYLE = "ultra"
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dict_bank_multi_if.slave       bus,
  output logic [$clog2(DEPTH):0] entry_count,
  output logic                   overflow
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  // Bounds check runs at the wider of id and count so high id bits are never lost.
  localparam int CMPW = (ID_W > CW) ? ID_W : CW;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  logic [1:0]      state_reg;
  logic [CW-1:0]   wr_addr_reg;
  logic [CW-1:0]   entry_count_reg;
  logic            overflow_reg;
  logic [N_CH-1:0] done_reg;
  logic [N_CH-1:0] out_valid_reg;

  logic            value_fire;
  logic            wr_room;
  logic            wr_en;
  logic [N_CH-1:0] id_ready;
  logic [N_CH-1:0] id_fire;
  logic [N_CH-1:0] advance;
  logic [N_CH-1:0] done_next;

  assign wr_room    = (wr_addr_reg < CW'(DEPTH));
  assign value_fire = (state_reg == ST_LOAD) && bus.in_value_valid;
  assign wr_en      = value_fire && wr_room;

  // A channel's output register may take a new beat when it is empty or retiring.
  assign advance   = ~out_valid_reg | bus.out_ready;
  assign id_ready  = (state_reg == ST_LOOKUP) ? (~done_reg & advance) : '0;
  assign id_fire   = bus.in_id_valid & id_ready;
  assign done_next = done_reg | (id_fire & bus.in_id_last);

  assign bus.in_value_ready = (state_reg == ST_LOAD);
  assign bus.in_id_ready    = id_ready;
  assign bus.out_valid      = out_valid_reg;
  assign entry_count        = entry_count_reg;
  assign overflow           = overflow_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_LOAD;
      wr_addr_reg     <= '0;
      entry_count_reg <= '0;
      overflow_reg    <= 1'b0;
      done_reg        <= '0;
      out_valid_reg   <= '0;
    end else begin
      // Stalled lanes hold; advancing lanes load keep of an accepted beat, else go empty.
      out_valid_reg <= (out_valid_reg & ~advance) | (advance & id_fire & bus.in_id_keep);

      case (state_reg)
        ST_LOAD: begin
          if (value_fire) begin
            if (wr_room) begin
              wr_addr_reg     <= wr_addr_reg + CW'(1);
              entry_count_reg <= wr_addr_reg + CW'(1);
              // wr_addr is 0 only on the first beat of a load.
              if (wr_addr_reg == '0) overflow_reg <= 1'b0;
            end else begin
              overflow_reg <= 1'b1;
            end
            if (bus.in_value_last) begin
              state_reg   <= ST_LOOKUP;
              wr_addr_reg <= '0;
              done_reg    <= '0;
            end
          end
        end
        ST_LOOKUP: begin
          done_reg <= done_next;
          if (&done_next) state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (&advance) state_reg <= ST_LOAD;
        end
        default: state_reg <= ST_LOAD;
      endcase
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    (* ram_style = RAM_STYLE *) logic [VALUE_W-1:0] mem [DEPTH];
    logic [VALUE_W-1:0]  rd_data_reg;
    logic [SERIAL_W-1:0] serial_reg;
    logic                last_reg;
    logic                miss_reg;
    logic [ID_W-1:0]     id;

    assign id = bus.in_id_data[gi*ID_W +: ID_W];

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr_reg[AW-1:0]] <= bus.in_value_data;
    end

    // Read only on accept, so a stalled lane keeps its data without extra muxing.
    always_ff @(posedge clk) begin
      if (id_fire[gi]) rd_data_reg <= mem[id[AW-1:0]];
    end

    always_ff @(posedge clk) begin
      if (id_fire[gi]) begin
        serial_reg <= bus.in_id_serial[gi*SERIAL_W +: SERIAL_W];
        last_reg   <= bus.in_id_last[gi];
        miss_reg   <= (CMPW'(id) >= CMPW'(entry_count_reg));
      end
    end

    assign bus.out_value[gi*VALUE_W +: VALUE_W]    = miss_reg ? '0 : rd_data_reg;
    assign bus.out_serial[gi*SERIAL_W +: SERIAL_W] = serial_reg;
    assign bus.out_miss[gi]                        = miss_reg;
    assign bus.out_last[gi]                        = last_reg;
  end
endmodule

// File: tb/tb_dict_bank_multi.sv
// Self-checking bench for dict_bank_multi: directed lookups, a random-backpressure
// multi-channel session with a per-channel expectation model, overflow on a
// DEPTH=4 instance, and reset during a stalled lookup.
module tb_dict_bank_multi;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dict_bank_multi_if #(.VALUE_W(32), .ID_W(16), .SERIAL_W(8), .N_CH(4)) b0 ();
  dict_bank_multi_if #(.VALUE_W(32), .ID_W(16), .SERIAL_W(8), .N_CH(4)) b1 ();
  logic [4:0] ec0;
  logic       ov0;
  logic [2:0] ec1;
  logic       ov1;

  dict_bank_multi #(.VALUE_W(32), .ID_W(16), .SERIAL_W(8), .DEPTH(16), .N_CH(4), .RAM_STYLE("block"))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(b0), .entry_count(ec0), .overflow(ov0));
  dict_bank_multi #(.VALUE_W(32), .ID_W(16), .SERIAL_W(8), .DEPTH(4), .N_CH(4), .RAM_STYLE("block"))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(b1), .entry_count(ec1), .overflow(ov1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit s, input int c, input int id, input int ser,
                        input bit keep, input bit last, input bit vld);
    if (!s) begin
      b0.in_id_data[c*16 +: 16] = 16'(id);
      b0.in_id_serial[c*8 +: 8] = 8'(ser);
      b0.in_id_keep[c] = keep; b0.in_id_last[c] = last; b0.in_id_valid[c] = vld;
    end else begin
      b1.in_id_data[c*16 +: 16] = 16'(id);
      b1.in_id_serial[c*8 +: 8] = 8'(ser);
      b1.in_id_keep[c] = keep; b1.in_id_last[c] = last; b1.in_id_valid[c] = vld;
    end
  endtask

  function automatic logic [31:0] oval(input bit s, input int c);
    return s ? b1.out_value[c*32 +: 32] : b0.out_value[c*32 +: 32];
  endfunction
  function automatic logic [7:0] oser(input bit s, input int c);
    return s ? b1.out_serial[c*8 +: 8] : b0.out_serial[c*8 +: 8];
  endfunction

  task automatic load(input bit s, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      if (!s) begin
        b0.in_value_valid = 1'b1; b0.in_value_data = 32'(base + i); b0.in_value_last = (i == n - 1);
      end else begin
        b1.in_value_valid = 1'b1; b1.in_value_data = 32'(base + i); b1.in_value_last = (i == n - 1);
      end
      tick();
    end
    b0.in_value_valid = 1'b0; b0.in_value_last = 1'b0;
    b1.in_value_valid = 1'b0; b1.in_value_last = 1'b0;
  endtask

  // Random session: dictionary value(i) = 1000 + 7*i, 16 entries.
  function automatic int id_of(input int c, input int k);
    return (k * 5 + c * 3) % 20;
  endfunction
  function automatic logic [31:0] exp_val(input int c, input int k);
    return (id_of(c, k) >= 16) ? 32'd0 : 32'(1000 + 7 * id_of(c, k));
  endfunction

  int        n_in [4] = '{16, 16, 5, 16};
  int        n_out[4] = '{16, 16, 4, 16};
  int        ptr  [4];
  int        rcnt [4];
  bit        stalled[4];
  logic [31:0] held_v[4];
  logic [7:0]  held_s[4];

  initial begin
    b0.in_value_data = '0; b0.in_value_valid = 1'b0; b0.in_value_last = 1'b0;
    b0.in_id_data = '0; b0.in_id_serial = '0; b0.in_id_keep = '0; b0.in_id_last = '0;
    b0.in_id_valid = '0; b0.out_ready = '0;
    b1.in_value_data = '0; b1.in_value_valid = 1'b0; b1.in_value_last = 1'b0;
    b1.in_id_data = '0; b1.in_id_serial = '0; b1.in_id_keep = '0; b1.in_id_last = '0;
    b1.in_id_valid = '0; b1.out_ready = '0;

    // ---- reset state ----
    tick(); tick();
    check("rst_value_ready", b0.in_value_ready, 1);
    check("rst_id_ready", b0.in_id_ready, 0);
    check("rst_out_valid", b0.out_valid, 0);
    check("rst_entry_count", ec0, 0);
    check("rst_overflow", ov0, 0);
    rst_n = 1'b1;
    tick();

    // ---- directed lookups, continuous ready ----
    load(0, 8, 100);
    check("A_entry_count", ec0, 8);
    check("A_value_ready_lookup", b0.in_value_ready, 0);
    check("A_id_ready_all", b0.in_id_ready, 4'hF);
    b0.out_ready = 4'hF;
    set_id(0, 0, 0, 1, 1, 0, 1);
    set_id(0, 1, 8, 11, 1, 0, 1);
    set_id(0, 2, 0, 0, 0, 1, 1);     // dummy last: no output
    set_id(0, 3, 1, 40, 1, 1, 1);
    tick();
    check("A0_out_valid", b0.out_valid, 4'b1011);
    check("A0_ch0_value", oval(0, 0), 100);
    check("A0_ch0_serial", oser(0, 0), 1);
    check("A0_ch0_miss", b0.out_miss[0], 0);
    check("A0_ch1_value_miss8", oval(0, 1), 0);
    check("A0_ch1_miss8", b0.out_miss[1], 1);
    check("A0_ch3_value", oval(0, 3), 101);
    check("A0_ch3_last", b0.out_last[3], 1);
    check("A0_id_ready_done", b0.in_id_ready, 4'b0011);
    set_id(0, 0, 7, 2, 1, 0, 1);
    set_id(0, 1, 40000, 12, 1, 0, 1);
    set_id(0, 2, 0, 0, 0, 0, 0);
    set_id(0, 3, 0, 0, 0, 0, 0);
    tick();
    check("A1_out_valid", b0.out_valid, 4'b0011);
    check("A1_ch0_value", oval(0, 0), 107);
    check("A1_ch0_serial", oser(0, 0), 2);
    check("A1_ch1_value_miss40000", oval(0, 1), 0);
    check("A1_ch1_miss40000", b0.out_miss[1], 1);
    check("A1_ch1_serial", oser(0, 1), 12);
    set_id(0, 0, 3, 3, 1, 1, 1);
    set_id(0, 1, 5, 13, 1, 1, 1);
    tick();
    check("A2_ch0_value", oval(0, 0), 103);
    check("A2_ch0_serial", oser(0, 0), 3);
    check("A2_ch0_last", b0.out_last[0], 1);
    check("A2_ch1_value", oval(0, 1), 105);
    check("A2_ch1_miss", b0.out_miss[1], 0);
    check("A2_value_ready_drain", b0.in_value_ready, 0);
    check("A2_id_ready_drain", b0.in_id_ready, 0);
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_id(0, 1, 0, 0, 0, 0, 0);
    tick();
    check("A3_out_valid", b0.out_valid, 0);
    check("A3_back_to_load", b0.in_value_ready, 1);
    check("A3_entry_count", ec0, 8);

    // ---- random backpressure, 4 channels, ch2 ends with dummy last ----
    for (int i = 0; i < 16; i++) begin
      b0.in_value_valid = 1'b1; b0.in_value_data = 32'(1000 + 7 * i); b0.in_value_last = (i == 15);
      tick();
    end
    b0.in_value_valid = 1'b0; b0.in_value_last = 1'b0;
    check("B_entry_count", ec0, 16);
    check("B_overflow", ov0, 0);
    begin
      bit finished = 1'b0;
      int cyc = 0;
      while (!finished && cyc < 3000) begin
        cyc++;
        for (int c = 0; c < 4; c++) begin
          if (ptr[c] < n_in[c] && $urandom_range(0, 3) != 0)
            set_id(0, c, id_of(c, ptr[c]), c * 32 + ptr[c], !(c == 2 && ptr[c] == 4),
                   ptr[c] == n_in[c] - 1, 1);
          else
            b0.in_id_valid[c] = 1'b0;
          b0.out_ready[c] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("B_no_early_load", b0.in_value_ready, 0);
        for (int c = 0; c < 4; c++) begin
          if (stalled[c]) begin
            check($sformatf("B_ch%0d_hold_valid", c), b0.out_valid[c], 1);
            check($sformatf("B_ch%0d_hold_value", c), oval(0, c), held_v[c]);
            check($sformatf("B_ch%0d_hold_serial", c), oser(0, c), held_s[c]);
          end
          if (b0.out_valid[c]) begin
            if (b0.out_ready[c]) begin
              check($sformatf("B_ch%0d_beat%0d_value", c, rcnt[c]), oval(0, c), exp_val(c, rcnt[c]));
              check($sformatf("B_ch%0d_beat%0d_serial", c, rcnt[c]), oser(0, c), 8'(c * 32 + rcnt[c]));
              check($sformatf("B_ch%0d_beat%0d_miss", c, rcnt[c]), b0.out_miss[c],
                    id_of(c, rcnt[c]) >= 16);
              check($sformatf("B_ch%0d_beat%0d_last", c, rcnt[c]), b0.out_last[c],
                    c != 2 && rcnt[c] == 15);
              rcnt[c]++;
              stalled[c] = 1'b0;
            end else begin
              stalled[c] = 1'b1;
              held_v[c] = oval(0, c);
              held_s[c] = oser(0, c);
            end
          end
          if (b0.in_id_valid[c] && b0.in_id_ready[c]) ptr[c]++;
        end
        finished = 1'b1;
        for (int c = 0; c < 4; c++)
          if (rcnt[c] != n_out[c] || ptr[c] != n_in[c]) finished = 1'b0;
        @(posedge clk);
        #1;
      end
      if (!finished) check("B_timeout", 0, 1);
      b0.in_id_valid = '0;
      tick();
      check("B_back_to_load", b0.in_value_ready, 1);
      check("B_out_valid_clear", b0.out_valid, 0);
      for (int c = 0; c < 4; c++)
        check($sformatf("B_ch%0d_count", c), rcnt[c], n_out[c]);
    end

    // ---- DEPTH=4 overflow ----
    load(1, 6, 1);
    check("C_entry_count", ec1, 4);
    check("C_overflow", ov1, 1);
    b1.out_ready = 4'hF;
    set_id(1, 0, 3, 5, 1, 0, 1);
    set_id(1, 1, 0, 0, 0, 1, 1);
    set_id(1, 2, 0, 0, 0, 1, 1);
    set_id(1, 3, 0, 0, 0, 1, 1);
    tick();
    check("C_id3_valid", b1.out_valid, 4'b0001);
    check("C_id3_value", oval(1, 0), 4);
    check("C_id3_miss", b1.out_miss[0], 0);
    b1.in_id_valid = '0;
    set_id(1, 0, 4, 6, 1, 1, 1);
    tick();
    check("C_id4_value", oval(1, 0), 0);
    check("C_id4_miss", b1.out_miss[0], 1);
    b1.in_id_valid = '0;
    tick();
    check("C_back_to_load", b1.in_value_ready, 1);
    load(1, 2, 9);
    check("C2_overflow_cleared", ov1, 0);
    check("C2_entry_count", ec1, 2);

    // ---- reset during a stalled lookup ----
    load(0, 4, 50);
    b0.out_ready = '0;
    set_id(0, 0, 2, 7, 1, 0, 1);
    tick();
    b0.in_id_valid = '0;
    check("D_out_valid_before", b0.out_valid[0], 1);
    check("D_value_before", oval(0, 0), 52);
    rst_n = 1'b0;
    tick();
    check("D_out_valid_after", b0.out_valid, 0);
    check("D_value_ready_after", b0.in_value_ready, 1);
    check("D_entry_count_after", ec0, 0);
    check("D_id_ready_after", b0.in_id_ready, 0);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
